// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings for the PWM measurement block (duty classes, FSM states).
package pwm_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;
  localparam logic [1:0] DC_OTHER = 2'd0;
  localparam logic [1:0] DC_25    = 2'd1;
  localparam logic [1:0] DC_50    = 2'd2;
  localparam logic [1:0] DC_75    = 2'd3;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-flop synchronizer, optional debounce (PWM_MEAS_GLITCH_EN), rise/fall pulses.
module pwm_sync_edge #(
  parameter int GLITCH_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2} <= 2'b00;
    else {s1, s2} <= {pwm_in, s1};
`ifdef PWM_MEAS_GLITCH_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);
  logic [GW-1:0] gcnt;
  logic filt;
  // filt follows s2 only after GLITCH_CYC consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gcnt <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) gcnt <= '0;
    else if (gcnt == GW'(GLITCH_CYC - 1)) begin
      filt <= s2;
      gcnt <= '0;
    end else gcnt <= gcnt + 1'b1;
  assign level = filt;
`else
  assign level = s2;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) prev <= 1'b0;
    else prev <= level;
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/pwm_meas.sv
// pwm_meas: measures PWM high time and period in clk cycles and classifies duty as 25/50/75 %.
// Optional input debounce enabled by defining PWM_MEAS_GLITCH_EN.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int TOL        = 2,
  parameter int GLITCH_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [1:0]       duty_class,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);
  localparam int W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_t st;
  logic [CNT_W-1:0] hcnt, pcnt;
  logic level, rise, fall;
  logic [W-1:0] h4, p1;
  logic [1:0] cls;
  pwm_sync_edge #(.GLITCH_CYC(GLITCH_CYC)) u_sync (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .level(level), .rise(rise), .fall(fall)
  );
  function automatic logic [W-1:0] adiff(input logic [W-1:0] a, input logic [W-1:0] b);
    return a > b ? a - b : b - a;
  endfunction
  // lowest matching quarter wins
  always_comb begin
    h4  = {hcnt, 2'b00};
    p1  = {2'b00, pcnt};
    cls = adiff(h4, p1) <= W'(TOL) ? DC_25 :
          adiff(h4, p1 << 1) <= W'(TOL) ? DC_50 :
          adiff(h4, p1 + (p1 << 1)) <= W'(TOL) ? DC_75 : DC_OTHER;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st          <= ST_IDLE;
      hcnt        <= '0;
      pcnt        <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_class  <= DC_OTHER;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (st == ST_IDLE) begin
        if (rise) begin
          st   <= ST_HIGH;
          hcnt <= CNT_W'(1);
          pcnt <= CNT_W'(1);
        end
      end else if (pcnt == CMAX) begin
        timeout     <= 1'b1;
        stuck_level <= level;
        st          <= ST_IDLE;
      end else if (st == ST_HIGH) begin
        pcnt <= pcnt + 1'b1;
        if (fall) st <= ST_LOW;
        else hcnt <= hcnt + 1'b1;
      end else if (rise) begin
        high_cnt   <= hcnt;
        period_cnt <= pcnt;
        duty_class <= cls;
        meas_valid <= 1'b1;
        timeout    <= 1'b0;
        hcnt       <= CNT_W'(1);
        pcnt       <= CNT_W'(1);
        st         <= ST_HIGH;
      end else pcnt <= pcnt + 1'b1;
    end
endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: directed checks of pwm_meas (CNT_W=8) with hand-computed expectations.
module tb_pwm_meas;
  logic clk = 1'b0;
  logic rst, pwm_in;
  logic [7:0] high_cnt, period_cnt;
  logic [1:0] duty_class;
  logic meas_valid, timeout, stuck_level;
  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int base;
  pwm_meas #(.CNT_W(8), .TOL(2), .GLITCH_CYC(3)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_cnt(high_cnt), .period_cnt(period_cnt),
    .duty_class(duty_class), .meas_valid(meas_valid), .timeout(timeout), .stuck_level(stuck_level)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (meas_valid === 1'b1) nvalid++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic run(input int h, input int l, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask
  task automatic rise_wait();
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic chk_meas(input string tag, input int h, input int p, input int c);
    chk({tag, "_high"}, high_cnt, h);
    chk({tag, "_period"}, period_cnt, p);
    chk({tag, "_class"}, duty_class, c);
  endtask
  initial begin
    rst = 1'b0;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_meas("rst", 0, 0, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_stuck", stuck_level, 0);
    rst = 1'b1;
    @(negedge clk);
    base = nvalid;
    run(2, 6, 4);
    rise_wait();
    chk_meas("p2_6", 2, 8, 1);
    chk("p2_6_nvalid", nvalid - base, 4);
    run(4, 4, 3);
    rise_wait();
    chk_meas("p4_4", 4, 8, 2);
    run(6, 2, 3);
    rise_wait();
    chk_meas("p6_2", 6, 8, 3);
    run(3, 5, 3);
    rise_wait();
    chk_meas("p3_5", 3, 8, 0);
    run(1, 7, 3);
    rise_wait();
    chk_meas("p1_7", 1, 8, 0);
    base = nvalid;
    run(4, 5, 1);
    run(2, 5, 1);
    rise_wait();
    chk_meas("spike", 2, 7, 1);
    chk("spike_nvalid", nvalid - base, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    pwm_in = 1'b0;
    #10 rst = 1'b1;
    @(negedge clk);
    chk_meas("midrst", 0, 0, 0);
    chk("midrst_timeout", timeout, 0);
    base = nvalid;
    rise_wait();
    chk("midrst_first_rise", nvalid - base, 0);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    rise_wait();
    chk_meas("midrst_meas", 4, 8, 2);
    chk("midrst_nvalid", nvalid - base, 1);
    repeat (240) @(negedge clk);
    chk("hi_before_to", timeout, 0);
    repeat (20) @(negedge clk);
    chk("hi_timeout", timeout, 1);
    chk("hi_stuck", stuck_level, 1);
    chk_meas("hi_hold", 4, 8, 2);
    chk("hi_nvalid", nvalid - base, 1);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    base = nvalid;
    run(2, 6, 2);
    rise_wait();
    chk("restart_timeout", timeout, 0);
    chk_meas("restart", 2, 8, 1);
    chk("restart_nvalid", nvalid - base, 2);
    base = nvalid;
    pwm_in = 1'b0;
    repeat (270) @(negedge clk);
    chk("lo_timeout", timeout, 1);
    chk("lo_stuck", stuck_level, 0);
    chk("lo_nvalid", nvalid - base, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
